norm_scale_stage: RTL and testbench

Parametrised output stage of the RMS-norm datapath. Takes one beat of LANES bf16 activations plus a per-row bf16 scale (the inverse-sqrt RMS) and multiplies every lane by that scale. When gamma is enabled, the result is then multiplied by a per-element bf16 gamma weight held in an internal buffer indexed by beat position within the row. It sits directly after the inverse-sqrt stage and replaces the fixed 8-lane scale-only multiplier bank with an in-house, fully specified bf16 pipeline.

---
 rtl/norm_scale_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_norm_scale_stage.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_scale_stage.sv
// rtl/norm_scale_stage.sv - bf16 RMS-norm output stage: per-row scale, optional per-element gamma
// Ports:
//   aclk, arstn        clock, asynchronous active-low reset
//   s_axis_*           input beat {lane[LANES-1]..lane[0], scale[15:0]}, valid/ready
//   g_wr_en/addr/data  gamma buffer write port (one beat of LANES gamma values per address)
//   m_axis_*           result lanes, valid/ready, tlast on the last beat of a row

module norm_scale_stage #(
   parameter int LANES     = 8,
   parameter int ROW_BEATS = 16,
   parameter bit GAMMA_EN  = 1'b1,
   parameter int AW        = $clog2(ROW_BEATS)
) (
   input  logic                  aclk,
   input  logic                  arstn,
   input  logic [16*LANES+15:0]  s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  g_wr_en,
   input  logic [AW-1:0]         g_wr_addr,
   input  logic [16*LANES-1:0]   g_wr_data,
   output logic [16*LANES-1:0]   m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   localparam int DW = 16*LANES;

   // First half of a bf16 multiply: special-case flags are resolved here so
   // the second stage only has to normalise and round.
   typedef struct packed {
      logic        sign;
      logic        nan;
      logic        inf;
      logic        zero;
      logic [8:0]  esum;
      logic [15:0] prod;
   } mul_a_t;

   function automatic mul_a_t mul_stage_a(input logic [15:0] a, input logic [15:0] b);
      mul_a_t r;
      logic   a_z, b_z, a_f, b_f;
      a_z    = (a[14:7] == 8'h00);
      b_z    = (b[14:7] == 8'h00);
      a_f    = (a[14:7] == 8'hFF);
      b_f    = (b[14:7] == 8'hFF);
      r.sign = a[15] ^ b[15];
      r.nan  = (a_f & (|a[6:0])) | (b_f & (|b[6:0])) | (a_f & b_z) | (b_f & a_z);
      r.inf  = (a_f | b_f) & ~r.nan;
      // subnormals flush to zero unless the other side is inf/NaN
      r.zero = (a_z | b_z) & ~a_f & ~b_f;
      r.esum = {1'b0, a[14:7]} + {1'b0, b[14:7]};
      r.prod = {8'b0, 1'b1, a[6:0]} * {8'b0, 1'b1, b[6:0]};
      return r;
   endfunction

   function automatic logic [15:0] mul_stage_b(input mul_a_t r);
      logic [6:0]         m;
      logic               g, s, up;
      logic [7:0]         m_r;
      logic signed [10:0] e;
      logic [15:0]        res;
      if (r.prod[15]) begin
         m = r.prod[14:8];
         g = r.prod[7];
         s = |r.prod[6:0];
         e = $signed({2'b00, r.esum}) - 11'sd126;
      end else begin
         m = r.prod[13:7];
         g = r.prod[6];
         s = |r.prod[5:0];
         e = $signed({2'b00, r.esum}) - 11'sd127;
      end
      up  = g & (s | m[0]);
      m_r = {1'b0, m} + {7'b0, up};
      // mantissa carry-out leaves m_r[6:0] at zero and bumps the exponent
      if (m_r[7]) e = e + 11'sd1;
      res = {r.sign, e[7:0], m_r[6:0]};
      if (r.nan)                res = 16'h7FC0;
      else if (r.inf)           res = {r.sign, 8'hFF, 7'h00};
      else if (r.zero)          res = {r.sign, 15'h0000};
      else if (e >= 11'sd255)   res = {r.sign, 8'hFF, 7'h00};
      else if (e <= 11'sd0)     res = {r.sign, 15'h0000};
      return res;
   endfunction

   logic          ce, acc, row_end;
   logic [AW-1:0] beat_cnt_q, beat_cnt_d;
   logic          a1_v_q, a1_v_d, a1_last_q, a1_last_d;
   mul_a_t        a1_q [LANES];
   mul_a_t        a1_d [LANES];
   logic          out_v_q, out_v_d, out_last_q, out_last_d;
   logic [DW-1:0] out_data_q, out_data_d;

   // One enable for the whole pipe, taken from the output register only.
   assign ce            = !out_v_q || m_axis_tready;
   assign s_axis_tready = ce;
   assign acc           = s_axis_tvalid && ce;
   assign row_end       = (beat_cnt_q == AW'(ROW_BEATS-1));

   assign m_axis_tvalid = out_v_q;
   assign m_axis_tlast  = out_last_q;
   assign m_axis_tdata  = out_data_q;

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      a1_v_d     = a1_v_q;
      a1_last_d  = a1_last_q;
      a1_d       = a1_q;
      if (acc) beat_cnt_d = row_end ? '0 : beat_cnt_q + AW'(1);
      if (ce) begin
         a1_v_d    = s_axis_tvalid;
         a1_last_d = row_end;
         for (int i = 0; i < LANES; i++)
            a1_d[i] = mul_stage_a(s_axis_tdata[16*i+16 +: 16], s_axis_tdata[15:0]);
      end
   end

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         beat_cnt_q <= '0;
         a1_v_q     <= 1'b0;
         a1_last_q  <= 1'b0;
         a1_q       <= '{default: '0};
         out_v_q    <= 1'b0;
         out_last_q <= 1'b0;
         out_data_q <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         a1_v_q     <= a1_v_d;
         a1_last_q  <= a1_last_d;
         a1_q       <= a1_d;
         out_v_q    <= out_v_d;
         out_last_q <= out_last_d;
         out_data_q <= out_data_d;
      end
   end

   if (GAMMA_EN) begin : g_gamma
      logic [DW-1:0] gbuf_q [ROW_BEATS];
      logic [DW-1:0] gbuf_d [ROW_BEATS];
      logic [AW-1:0] idx1_q, idx1_d, idx2_q, idx2_d;
      logic          b1_v_q, b1_v_d, b1_last_q, b1_last_d;
      logic [DW-1:0] b1_data_q, b1_data_d;
      logic          a2_v_q, a2_v_d, a2_last_q, a2_last_d;
      mul_a_t        a2_q [LANES];
      mul_a_t        a2_d [LANES];

      always_comb begin
         gbuf_d = gbuf_q;
         if (g_wr_en) gbuf_d[g_wr_addr] = g_wr_data;
      end

      // gamma weights survive reset
      always_ff @(posedge aclk) gbuf_q <= gbuf_d;

      always_comb begin
         idx1_d     = idx1_q;
         idx2_d     = idx2_q;
         b1_v_d     = b1_v_q;
         b1_last_d  = b1_last_q;
         b1_data_d  = b1_data_q;
         a2_v_d     = a2_v_q;
         a2_last_d  = a2_last_q;
         a2_d       = a2_q;
         out_v_d    = out_v_q;
         out_last_d = out_last_q;
         out_data_d = out_data_q;
         if (ce) begin
            idx1_d    = beat_cnt_q;
            idx2_d    = idx1_q;
            b1_v_d    = a1_v_q;
            b1_last_d = a1_last_q;
            a2_v_d    = b1_v_q;
            a2_last_d = b1_last_q;
            out_v_d   = a2_v_q;
            out_last_d = a2_last_q;
            for (int i = 0; i < LANES; i++) begin
               b1_data_d[16*i +: 16]  = mul_stage_b(a1_q[i]);
               a2_d[i]                = mul_stage_a(b1_data_q[16*i +: 16], gbuf_q[idx2_q][16*i +: 16]);
               out_data_d[16*i +: 16] = mul_stage_b(a2_q[i]);
            end
         end
      end

      always_ff @(posedge aclk or negedge arstn) begin
         if (!arstn) begin
            idx1_q    <= '0;
            idx2_q    <= '0;
            b1_v_q    <= 1'b0;
            b1_last_q <= 1'b0;
            b1_data_q <= '0;
            a2_v_q    <= 1'b0;
            a2_last_q <= 1'b0;
            a2_q      <= '{default: '0};
         end else begin
            idx1_q    <= idx1_d;
            idx2_q    <= idx2_d;
            b1_v_q    <= b1_v_d;
            b1_last_q <= b1_last_d;
            b1_data_q <= b1_data_d;
            a2_v_q    <= a2_v_d;
            a2_last_q <= a2_last_d;
            a2_q      <= a2_d;
         end
      end
   end else begin : g_scale
      logic unused_gamma;
      assign unused_gamma = ^{g_wr_en, g_wr_addr, g_wr_data};

      always_comb begin
         out_v_d    = out_v_q;
         out_last_d = out_last_q;
         out_data_d = out_data_q;
         if (ce) begin
            out_v_d    = a1_v_q;
            out_last_d = a1_last_q;
            for (int i = 0; i < LANES; i++)
               out_data_d[16*i +: 16] = mul_stage_b(a1_q[i]);
         end
      end
   end

endmodule

// File: tb/tb_norm_scale_stage.sv
// tb/tb_norm_scale_stage.sv - scoreboard bench for norm_scale_stage, gamma and scale-only instances

module tb_norm_scale_stage;

   localparam int LANES = 8;
   localparam int RB    = 4;
   localparam int DW    = 16*LANES;

   logic          aclk  = 1'b0;
   logic          arstn = 1'b0;
   logic [DW+15:0] s_tdata = '0;
   logic          sv [2];
   logic          s_r [2];
   logic          m_r = 1'b1;
   logic          m_v [2];
   logic          m_l [2];
   logic [DW-1:0] m_d [2];
   logic          g_we = 1'b0;
   logic [1:0]    g_wa = '0;
   logic [DW-1:0] g_wd = '0;

   always #5 aclk = ~aclk;

   norm_scale_stage #(.LANES(LANES), .ROW_BEATS(RB), .GAMMA_EN(1'b1)) dut_g (
      .aclk(aclk), .arstn(arstn),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(sv[0]), .s_axis_tready(s_r[0]),
      .g_wr_en(g_we), .g_wr_addr(g_wa), .g_wr_data(g_wd),
      .m_axis_tdata(m_d[0]), .m_axis_tvalid(m_v[0]), .m_axis_tready(m_r), .m_axis_tlast(m_l[0]));

   norm_scale_stage #(.LANES(LANES), .ROW_BEATS(RB), .GAMMA_EN(1'b0)) dut_s (
      .aclk(aclk), .arstn(arstn),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(sv[1]), .s_axis_tready(s_r[1]),
      .g_wr_en(g_we), .g_wr_addr(g_wa), .g_wr_data(g_wd),
      .m_axis_tdata(m_d[1]), .m_axis_tvalid(m_v[1]), .m_axis_tready(m_r), .m_axis_tlast(m_l[1]));

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      int            cyc;
      bit            chk_lat;
   } exp_t;

   exp_t        q [2][$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          bc [2];
   int          lat [2] = '{4, 2};
   logic [15:0] gmodel [RB][LANES];
   int          rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

   always @(posedge aclk) cyc <= cyc + 1;

   initial forever begin
      @(negedge aclk);
      if (rdy_mode == 0)      m_r = 1'b1;
      else if (rdy_mode == 1) m_r = 1'($urandom_range(0, 1));
      else                    m_r = 1'b0;
   end

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Reference: exact product in double precision, then round-to-nearest-even to 7 fraction bits.
   function automatic real bf_mag(input logic [15:0] x);
      return (1.0 + real'(x[6:0]) / 128.0) * (2.0 ** (real'(int'(x[14:7])) - 127.0));
   endfunction

   function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      logic        sgn;
      bit          an, bn, ai, bi, az, bz;
      real         p;
      logic [63:0] rb;
      logic [44:0] rest, half;
      int          e, km;
      sgn = a[15] ^ b[15];
      az  = (a[14:7] == 8'h00);
      bz  = (b[14:7] == 8'h00);
      an  = (a[14:7] == 8'hFF) && (a[6:0] != 0);
      bn  = (b[14:7] == 8'hFF) && (b[6:0] != 0);
      ai  = (a[14:7] == 8'hFF) && (a[6:0] == 0);
      bi  = (b[14:7] == 8'hFF) && (b[6:0] == 0);
      if (an || bn) return 16'h7FC0;
      if (ai || bi) return (az || bz) ? 16'h7FC0 : {sgn, 8'hFF, 7'h00};
      if (az || bz) return {sgn, 15'h0000};
      p    = bf_mag(a) * bf_mag(b);
      rb   = $realtobits(p);
      e    = int'(rb[62:52]) - 1023 + 127;
      km   = int'(rb[51:45]);
      rest = rb[44:0];
      half = 45'd1 << 44;
      if (rest > half || (rest == half && (km % 2 == 1))) begin
         km++;
         if (km == 128) begin
            km = 0;
            e++;
         end
      end
      if (e >= 255) return {sgn, 8'hFF, 7'h00};
      if (e <= 0)   return {sgn, 15'h0000};
      return {sgn, 8'(e), 7'(km)};
   endfunction

   function automatic logic [DW-1:0] ref_beat(input logic [DW+15:0] d, input int id, input int idx);
      logic [DW-1:0] r;
      logic [15:0]   v;
      for (int i = 0; i < LANES; i++) begin
         v = ref_mul(d[16*i+16 +: 16], d[15:0]);
         if (id == 0) v = ref_mul(v, gmodel[idx][i]);
         r[16*i +: 16] = v;
      end
      return r;
   endfunction

   function automatic logic [15:0] rand_bf16();
      int          r;
      logic [15:0] x;
      r = $urandom_range(0, 15);
      x = 16'($urandom);
      if (r == 0)      x[14:7] = 8'h00;
      else if (r == 1) x[14:7] = 8'hFF;
      else if (r < 12) x[14:7] = 8'(110 + $urandom_range(0, 34));
      return x;
   endfunction

   function automatic logic [DW+15:0] rand_vec();
      logic [DW+15:0] d;
      for (int i = 0; i <= LANES; i++) d[16*i +: 16] = rand_bf16();
      return d;
   endfunction

   // Called at a negedge; returns at the negedge after both instances accepted the beat.
   task automatic send_beat(input logic [DW+15:0] d, input bit use_cg, input logic [15:0] cg,
                            input bit use_cs, input logic [15:0] cs);
      exp_t        e;
      int          guard;
      bit          hs [2];
      logic [15:0] cv;
      guard   = 0;
      hs[0]   = 0;
      hs[1]   = 0;
      s_tdata = d;
      sv[0]   = 1'b1;
      sv[1]   = 1'b1;
      while (sv[0] || sv[1]) begin
         #1;
         for (int id = 0; id < 2; id++) begin
            if (sv[id] && s_r[id] && !hs[id]) begin
               cv = (id == 0) ? cg : cs;
               if ((id == 0 && use_cg) || (id == 1 && use_cs)) e.data = {LANES{cv}};
               else e.data = ref_beat(d, id, bc[id]);
               e.last    = (bc[id] == RB-1);
               e.cyc     = cyc;
               e.chk_lat = (rdy_mode == 0);
               q[id].push_back(e);
               bc[id] = (bc[id] + 1) % RB;
               hs[id] = 1;
            end
         end
         @(negedge aclk);
         for (int id = 0; id < 2; id++) if (hs[id]) sv[id] = 1'b0;
         guard++;
         if (guard > 500) begin
            n_chk++;
            n_fail++;
            $display("FAIL send timeout: accepted g=%0d s=%0d required both", hs[0], hs[1]);
            sv[0] = 1'b0;
            sv[1] = 1'b0;
         end
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q[0].size() != 0 || q[1].size() != 0) && t < 300) begin
         @(negedge aclk);
         t++;
      end
      n_chk++;
      if (t >= 300) begin
         n_fail++;
         $display("FAIL drain timeout: pending g=%0d s=%0d required 0", q[0].size(), q[1].size());
      end
      repeat (2) @(negedge aclk);
   endtask

   task automatic load_gamma(input int k, input logic [DW-1:0] v);
      g_we = 1'b1;
      g_wa = 2'(k);
      g_wd = v;
      for (int i = 0; i < LANES; i++) gmodel[k][i] = v[16*i +: 16];
      @(negedge aclk);
      g_we = 1'b0;
   endtask

   // Monitor: pops the scoreboard on every output handshake and checks hold-while-stalled.
   initial begin
      logic [DW-1:0] hd [2];
      logic          hl [2];
      bit            stall [2];
      exp_t          e;
      stall[0] = 0;
      stall[1] = 0;
      forever begin
         @(negedge aclk);
         #2;
         for (int id = 0; id < 2; id++) begin
            if (!arstn) begin
               stall[id] = 0;
               continue;
            end
            if (stall[id]) begin
               check($sformatf("dut%0d stall data", id), m_d[id], hd[id]);
               check($sformatf("dut%0d stall tlast", id), DW'(m_l[id]), DW'(hl[id]));
               check($sformatf("dut%0d stall tvalid", id), DW'(m_v[id]), DW'(1));
            end
            stall[id] = m_v[id] && !m_r;
            hd[id]    = m_d[id];
            hl[id]    = m_l[id];
            if (m_v[id] && m_r) begin
               if (q[id].size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL dut%0d unexpected output: got %h required none", id, m_d[id]);
               end else begin
                  e = q[id].pop_front();
                  check($sformatf("dut%0d data", id), m_d[id], e.data);
                  check($sformatf("dut%0d tlast", id), DW'(m_l[id]), DW'(e.last));
                  if (e.chk_lat) check($sformatf("dut%0d latency", id), DW'(cyc - e.cyc), DW'(lat[id]));
               end
            end
         end
      end
   end

   logic [15:0] dir_tab [8][3] = '{
      '{16'h4040, 16'h3FC0, 16'h4090},
      '{16'h3F81, 16'h3F81, 16'h3F82},
      '{16'h3F81, 16'h3FC0, 16'h3FC2},
      '{16'h7F80, 16'h0000, 16'h7FC0},
      '{16'hFF80, 16'h4000, 16'hFF80},
      '{16'h0001, 16'h4000, 16'h0000},
      '{16'h7F00, 16'h7F00, 16'h7F80},
      '{16'h0080, 16'h0080, 16'h0000}
   };

   initial begin
      logic [DW-1:0]  gv;
      logic [15:0]    p16;
      sv[0] = 1'b0;
      sv[1] = 1'b0;
      bc[0] = 0;
      bc[1] = 0;
      repeat (3) @(negedge aclk);
      arstn = 1'b1;
      #1;
      for (int id = 0; id < 2; id++) begin
         check($sformatf("dut%0d reset tvalid", id), DW'(m_v[id]), DW'(0));
         check($sformatf("dut%0d reset tlast", id), DW'(m_l[id]), DW'(0));
         check($sformatf("dut%0d reset tdata", id), m_d[id], '0);
         check($sformatf("dut%0d reset tready", id), DW'(s_r[id]), DW'(1));
      end
      @(negedge aclk);

      // gamma 1.0, 2.0, 4.0, 8.0 per beat; row of 0.5 -> 0.5, 1, 2, 4
      for (int k = 0; k < RB; k++) begin
         p16 = 16'(16'h3F80 + k*16'h0080);
         load_gamma(k, {LANES{p16}});
      end
      for (int b = 0; b < 2*RB; b++) begin
         p16 = 16'(16'h3F00 + (b % RB)*16'h0080);
         send_beat({{LANES{16'h3F80}}, 16'h3F00}, 1, p16, 1, 16'h3F00);
      end
      drain();

      // rounding and special cases, scale-only instance against fixed results
      for (int v = 0; v < 8; v++)
         send_beat({{LANES{dir_tab[v][0]}}, dir_tab[v][1]}, 0, 16'h0, 1, dir_tab[v][2]);
      drain();

      for (int k = 0; k < RB; k++) begin
         for (int i = 0; i < LANES; i++) begin
            p16 = 16'($urandom);
            p16[14:7] = 8'(120 + $urandom_range(0, 14));
            gv[16*i +: 16] = p16;
         end
         load_gamma(k, gv);
      end

      for (int b = 0; b < 20; b++) send_beat(rand_vec(), 0, 16'h0, 0, 16'h0);
      rdy_mode = 1;
      for (int b = 0; b < 64; b++) send_beat(rand_vec(), 0, 16'h0, 0, 16'h0);
      drain();
      rdy_mode = 0;
      drain();

      // full pipe, output held off for 10 cycles
      rdy_mode = 2;
      fork
         begin
            for (int b = 0; b < 6; b++) send_beat(rand_vec(), 0, 16'h0, 0, 16'h0);
         end
         begin
            repeat (8) @(negedge aclk);
            for (int c = 0; c < 10; c++) begin
               @(negedge aclk);
               #1;
               check("stall s_tready g", DW'(s_r[0]), DW'(0));
               check("stall s_tready s", DW'(s_r[1]), DW'(0));
            end
            rdy_mode = 0;
         end
      join
      drain();

      // reset in the middle of a row, gamma must be retained
      for (int k = 0; k < RB; k++) begin
         p16 = 16'(16'h3F80 + k*16'h0080);
         load_gamma(k, {LANES{p16}});
      end
      while (bc[0] != 0) send_beat(rand_vec(), 0, 16'h0, 0, 16'h0);
      drain();
      for (int b = 0; b < 3; b++) send_beat(rand_vec(), 0, 16'h0, 0, 16'h0);
      arstn = 1'b0;
      #1;
      check("mid-reset tvalid g", DW'(m_v[0]), DW'(0));
      check("mid-reset tvalid s", DW'(m_v[1]), DW'(0));
      q[0].delete();
      q[1].delete();
      bc[0] = 0;
      bc[1] = 0;
      repeat (2) @(negedge aclk);
      arstn = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge aclk);
         #1;
         check("post-reset idle g", DW'(m_v[0]), DW'(0));
         check("post-reset idle s", DW'(m_v[1]), DW'(0));
      end
      @(negedge aclk);
      for (int b = 0; b < RB; b++) begin
         p16 = 16'(16'h3F00 + b*16'h0080);
         send_beat({{LANES{16'h3F80}}, 16'h3F00}, 1, p16, 1, 16'h3F00);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
